keypad_scanner: RTL and testbench

Scanned 4x4 matrix-keypad input front end: the input-side counterpart of the multiplexed 7-segment output path. It drives one keypad column at a time and samples the four row lines. It debounces over whole scan frames and emits a one-cycle valid pulse with a 4-bit key code per accepted press. The key code feeds the counter/entry logic in place of the single count-up button.

---
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: column drive and row sense toward the matrix, plus the
// accepted-key outputs toward the entry logic.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (input row, output col, key, key_valid, key_held);
  modport slave  (output row, input col, key, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot column drive, synchronized row sampling,
// per-frame classification and frame-level press/release debounce.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  keypad_scanner_if.master  kp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_t;

  logic [3:0]    row_meta, row_sync;
  logic [PW-1:0] presc;
  logic [1:0]    col;
  logic          tick, frame_end;

  logic [1:0]    press_cnt;
  logic [3:0]    first_code;

  logic [2:0]    hits, tot;
  logic [1:0]    low_row;
  logic [3:0]    col_code, frame_code;
  logic          res_none, res_one;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    cand, cand_n, key, key_n;
  logic          key_valid, valid_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= kp.row;
      row_sync <= row_meta;
    end
  end

  assign tick      = (presc == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (col == 2'd3);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc <= '0;
      col   <= '0;
    end else if (tick) begin
      presc <= '0;
      col   <= col + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Classify the current column's sample merged with what the frame has seen so far.
  always_comb begin
    low_row = '0;
    for (int r = 3; r >= 0; r--)
      if (row_sync[r]) low_row = 2'(r);
    hits       = 3'(row_sync[0]) + 3'(row_sync[1]) + 3'(row_sync[2]) + 3'(row_sync[3]);
    tot        = 3'(press_cnt) + hits;
    col_code   = {low_row, col};
    frame_code = (press_cnt != 2'd0) ? first_code : col_code;
    res_none   = (tot == 3'd0);
    res_one    = (tot == 3'd1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      press_cnt  <= '0;
      first_code <= '0;
    end else if (tick) begin
      if (col == 2'd3) begin
        press_cnt  <= '0;
        first_code <= '0;
      end else begin
        press_cnt <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
        if (press_cnt == 2'd0 && hits != 3'd0) first_code <= col_code;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key       <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key       <= key_n;
      key_valid <= valid_n;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    key_n   = key;
    valid_n = 1'b0;
    if (frame_end) begin
      unique case (state)
        IDLE: if (res_one) begin
          state_n = PRESS_DEB;
          cand_n  = frame_code;
          cnt_n   = CW'(1);
        end
        PRESS_DEB: begin
          if (res_one && frame_code == cand) begin
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_n = HELD;
              cnt_n   = '0;
              key_n   = cand;
              valid_n = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        // Rollover to a different key while held is deliberately ignored.
        HELD: begin
          if (res_none) begin
            state_n = RELEASE_DEB;
            cnt_n   = CW'(1);
          end else begin
            cnt_n = '0;
          end
        end
        RELEASE_DEB: begin
          if (res_none) begin
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = HELD;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign kp.col       = 4'b0001 << col;
  assign kp.key       = key;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = (state == HELD) || (state == RELEASE_DEB);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a matrix model closes keys on the driven
// column; expected pulses (code, cycle) are queued at stimulus time.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  int          cyc = 0;
  int          n_chk = 0, n_err = 0;
  int          c, r;

  typedef struct {logic [3:0] code; int at;} exp_t;
  exp_t sb[$];

  keypad_scanner_if bus();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .kp    (bus.master)
  );

  always #5 clk = ~clk;

  // Row r reads high when a closed key on row r sits on the driven column.
  always_comb begin
    bus.row = '0;
    for (int i = 0; i < 4; i++) bus.row[i] = |(keys[4*i +: 4] & bus.col);
  end

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0; else cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.key_valid !== 1'b0) begin
      chk("pulse_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_code", 32'(bus.key), 32'(e.code));
        chk("pulse_cycle", cyc, e.at);
        chk("held_at_pulse", 32'(bus.key_held), 32'd1);
      end
    end
  end

  task automatic wait_until(input int t);
    for (int i = 0; i < 4000; i++) begin
      if (cyc == t) break;
      @(negedge clk);
    end
    chk("wait_until", cyc, t);
  endtask

  task automatic align(output int t);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (cyc % 16 == 0) break;
    end
    chk("align", cyc % 16, 0);
    t = cyc;
  endtask

  task automatic push(input logic [3:0] code, input int at);
    exp_t e;
    e.code = code;
    e.at   = at;
    sb.push_back(e);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_col", bus.col, 4'b0001);
    chk("rst_key", bus.key, 4'd0);
    chk("rst_valid", bus.key_valid, 1'b0);
    chk("rst_held", bus.key_held, 1'b0);
    rst = 1'b0;

    // Idle scan: column walks every SCAN_DIV cycles, nothing reported.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_col", bus.col, 4'b0001 << ((cyc / 4) % 4));
    end
    chk("idle_key", bus.key, 4'd0);
    chk("idle_held", bus.key_held, 1'b0);

    // Clean press of key 9 (row 2, column 1), held 5 frames.
    align(c);
    keys[9] = 1'b1;
    push(4'd9, c + 48);
    wait_until(c + 47);
    chk("clean_held_early", bus.key_held, 1'b0);
    wait_until(c + 80);
    keys = '0;
    r = cyc;
    wait_until(r + 32);
    chk("clean_held_rel2", bus.key_held, 1'b1);
    chk("clean_key_kept", bus.key, 4'd9);
    wait_until(r + 48);
    chk("clean_held_rel3", bus.key_held, 1'b0);
    chk("clean_key_after", bus.key, 4'd9);

    // Bouncing key 5 for 4 frames, then stable.
    align(c);
    for (int i = 0; i < 64; i++) begin
      keys[5] = ((i / 7) % 2 == 0);
      @(negedge clk);
    end
    keys[5] = 1'b1;
    push(4'd5, c + 112);
    wait_until(c + 120);
    chk("bounce_sb_empty", sb.size(), 0);
    keys = '0;
    wait_until(c + 184);
    chk("bounce_released", bus.key_held, 1'b0);

    // Two keys together: never accepted; releasing one accepts the other.
    align(c);
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    wait_until(c + 96);
    chk("multi_held", bus.key_held, 1'b0);
    chk("multi_key", bus.key, 4'd5);
    keys[15] = 1'b0;
    push(4'd0, c + 144);
    wait_until(c + 160);
    chk("multi_sb_empty", sb.size(), 0);
    keys = '0;
    wait_until(c + 224);
    chk("multi_released", bus.key_held, 1'b0);

    // Single NONE frame while key 12 is held must not re-trigger.
    align(c);
    keys[12] = 1'b1;
    push(4'd12, c + 48);
    wait_until(c + 48);
    keys = '0;
    wait_until(c + 64);
    keys[12] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_until(c + 64 + 16 * i);
      chk("glitch_held", bus.key_held, 1'b1);
    end
    keys = '0;
    wait_until(c + 192);
    chk("glitch_released", bus.key_held, 1'b0);
    chk("glitch_key", bus.key, 4'd12);

    // Async reset while key 3 is held, key stays closed.
    align(c);
    keys[3] = 1'b1;
    push(4'd3, c + 48);
    wait_until(c + 55);
    chk("pre_rst_held", bus.key_held, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_col", bus.col, 4'b0001);
    chk("mid_rst_key", bus.key, 4'd0);
    chk("mid_rst_valid", bus.key_valid, 1'b0);
    chk("mid_rst_held", bus.key_held, 1'b0);
    @(negedge clk);
    push(4'd3, 48);
    rst = 1'b0;
    wait_until(47);
    chk("post_rst_held_early", bus.key_held, 1'b0);
    chk("post_rst_key_early", bus.key, 4'd0);
    wait_until(60);
    chk("post_rst_key", bus.key, 4'd3);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
